// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: the slot-occupancy state
// encodings used when the skid slot is built (PIPE_STAGE_SKID_EN), and the
// default NOP payload used as the reset/flush value.
package pipe_stage_reg_pkg;

    // Occupancy of the stage: main slot only, or main plus skid slot.
    typedef enum logic [1:0] {
        PipeEmpty = 2'b00,
        PipeFull  = 2'b01,
        PipeSkid  = 2'b11
    } pipe_state_e;

    // Payload loaded by reset and flush unless a stage overrides RESET_VAL.
    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_reg_bank.sv
// WIDTH-bit register bank with load enable and asynchronous active-low reset
// to RESET_VAL. Holds one payload slot of the pipeline stage register.
module pipe_stage_reg_bank #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Load on enable; asynchronous reset forces the reset payload.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, back-pressure and
// synchronous flush. Define PIPE_STAGE_SKID_EN to add a second (skid) slot,
// which makes in_ready a pure register output and breaks the combinational
// out_ready -> in_ready path. Without it the stage is a single slot.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_NOP)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             w_accept;
    logic             w_emit;
    logic             w_main_en;
    logic [WIDTH-1:0] w_main_d;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    // Main slot: always holds the oldest live entry and drives out_data.
    pipe_stage_reg_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_bank (
        .i_clk   (clock),
        .i_rst_n (ctrl_reset),
        .i_en    (w_main_en),
        .i_d     (w_main_d),
        .o_q     (out_data)
    );

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_e      r_state;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_skid_en;
    logic [WIDTH-1:0] w_skid_d;
    logic [WIDTH-1:0] w_skid_q;

    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

    // Skid slot: catches the beat accepted while the main slot is stalled.
    pipe_stage_reg_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_bank (
        .i_clk   (clock),
        .i_rst_n (ctrl_reset),
        .i_en    (w_skid_en),
        .i_d     (w_skid_d),
        .o_q     (w_skid_q)
    );

    // Occupancy FSM with registered out_valid / in_ready.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_state     <= PipeEmpty;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= PipeEmpty;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                PipeEmpty: begin
                    if (w_accept) begin
                        r_state     <= PipeFull;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                PipeFull: begin
                    if (w_accept && !w_emit) begin
                        r_state    <= PipeSkid;
                        r_in_ready <= 1'b0;
                    end else if (!w_accept && w_emit) begin
                        r_state     <= PipeEmpty;
                        r_out_valid <= 1'b0;
                    end
                end
                PipeSkid: begin
                    if (w_emit) begin
                        r_state    <= PipeFull;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= PipeEmpty;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Slot enables and main-slot source select; skid drains into main on emit.
    always_comb begin
        w_main_en = 1'b0;
        w_main_d  = in_data;
        w_skid_en = 1'b0;
        w_skid_d  = in_data;
        if (flush) begin
            w_main_en = 1'b1;
            w_main_d  = RESET_VAL;
            w_skid_en = 1'b1;
            w_skid_d  = RESET_VAL;
        end else begin
            unique case (r_state)
                PipeEmpty: begin
                    w_main_en = w_accept;
                end
                PipeFull: begin
                    w_main_en = w_accept & w_emit;
                    w_skid_en = w_accept & ~w_emit;
                end
                PipeSkid: begin
                    if (w_emit) begin
                        w_main_en = 1'b1;
                        w_main_d  = w_skid_q;
                    end
                end
                default: begin
                    w_main_en = 1'b0;
                end
            endcase
        end
    end

`else

    logic r_valid;

    // Free when empty or when the held entry leaves this cycle.
    assign in_ready  = ~r_valid | out_ready;
    assign out_valid = r_valid;

    // Valid bit: flush wins, then accept refills, then emit drains.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (w_emit) begin
            r_valid <= 1'b0;
        end
    end

    // Payload loads on accept; flush discards any same-cycle beat.
    always_comb begin
        w_main_en = flush | w_accept;
        w_main_d  = flush ? RESET_VAL : in_data;
    end

`endif

endmodule
